// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port line-wide memory arbiter.
// The optional round-robin mode is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LINE_W_DEF = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY_I  = 2'b01,
      BUSY_D  = 2'b10,
      RELEASE = 2'b11
   } state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_I    = 2'b01;
   localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the icache and dcache requests.
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise dcache has fixed priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       i_req_i,
   input  logic       d_req_i,
`ifdef MEM_ARB_RR_EN
   input  logic       last_d_i,
`endif
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = GNT_NONE;
      if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
         // On a collision, hand the port to whoever was not served last.
         grant_o = last_d_i ? GNT_I : GNT_D;
`else
         // MEM-stage stalls are resolved first; icache may starve.
         grant_o = GNT_D;
`endif
      end else if (d_req_i) begin
         grant_o = GNT_D;
      end else if (i_req_i) begin
         grant_o = GNT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache refills and dcache refills/write-backs onto one Data_Memory port.
// Optional round-robin arbitration via MEM_ARB_RR_EN (default: dcache fixed priority).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_enable_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_ack_o,
   output logic [LINE_W-1:0] i_data_o,
   input  logic              d_enable_i,
   input  logic              d_write_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [LINE_W-1:0] d_data_i,
   output logic              d_ack_o,
   output logic [LINE_W-1:0] d_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic [1:0]        grant_o,
   output logic              proto_err_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic              write_q, write_d;
   logic              proto_err_q, proto_err_d;
   logic [1:0]        pick_gnt;

`ifdef MEM_ARB_RR_EN
   logic              last_d_q, last_d_d;
`endif

   mem_arb_pick u_pick (
      .i_req_i  (i_enable_i),
      .d_req_i  (d_enable_i),
`ifdef MEM_ARB_RR_EN
      .last_d_i (last_d_q),
`endif
      .grant_o  (pick_gnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         write_q     <= 1'b0;
         proto_err_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         write_q     <= write_d;
         proto_err_q <= proto_err_d;
`ifdef MEM_ARB_RR_EN
         last_d_q    <= last_d_d;
`endif
      end
   end

   // Next state and transaction latches; requests are only sampled in IDLE.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      write_d = write_q;
`ifdef MEM_ARB_RR_EN
      last_d_d = last_d_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_gnt == GNT_I) begin
               state_d = BUSY_I;
               addr_d  = i_addr_i;
               data_d  = '0;
               write_d = 1'b0;
`ifdef MEM_ARB_RR_EN
               last_d_d = 1'b0;
`endif
            end else if (pick_gnt == GNT_D) begin
               state_d = BUSY_D;
               addr_d  = d_addr_i;
               data_d  = d_data_i;
               write_d = d_write_i;
`ifdef MEM_ARB_RR_EN
               last_d_d = 1'b1;
`endif
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack_i) begin
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // An ack with no transaction in flight is a memory-side protocol fault.
   assign proto_err_d = proto_err_q |
                        (mem_ack_i & ((state_q == IDLE) | (state_q == RELEASE)));

   always_comb begin
      mem_enable_o = 1'b0;
      grant_o      = GNT_NONE;
      i_ack_o      = 1'b0;
      d_ack_o      = 1'b0;
      case (state_q)
         BUSY_I: begin
            mem_enable_o = 1'b1;
            grant_o      = GNT_I;
            i_ack_o      = mem_ack_i;
         end
         BUSY_D: begin
            mem_enable_o = 1'b1;
            grant_o      = GNT_D;
            d_ack_o      = mem_ack_i;
         end
         default: ;
      endcase
   end

   assign mem_write_o = write_q;
   assign mem_addr_o  = addr_q;
   assign mem_data_o  = data_q;
   assign proto_err_o = proto_err_q;

   // Read data fans out to both requesters; only the owner's ack qualifies it.
   assign i_data_o = mem_data_i;
   assign d_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected acks queued at stimulus, popped by a monitor.
// Honours MEM_ARB_RR_EN for the repeated-collision grant order.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int W  = LW + 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          i_enable_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic          i_ack_o;
  logic [LW-1:0] i_data_o;
  logic          d_enable_i = 1'b0;
  logic          d_write_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [LW-1:0] d_data_i = '0;
  logic          d_ack_o;
  logic [LW-1:0] d_data_o;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic          mem_ack_i = 1'b0;
  logic [LW-1:0] mem_data_i = '0;
  logic [1:0]    grant_o;
  logic          proto_err_o;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_e;
  logic [LW-1:0] mon_data;
  int            checks = 0;
  int            errors = 0;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_enable_i   (i_enable_i),
    .i_addr_i     (i_addr_i),
    .i_ack_o      (i_ack_o),
    .i_data_o     (i_data_o),
    .d_enable_i   (d_enable_i),
    .d_write_i    (d_write_i),
    .d_addr_i     (d_addr_i),
    .d_data_i     (d_data_i),
    .d_ack_o      (d_ack_o),
    .d_data_o     (d_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .grant_o      (grant_o),
    .proto_err_o  (proto_err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every ack pulse must match the head of the queue
  always @(negedge clk_i) begin
    if (i_ack_o === 1'b1 || d_ack_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack i_ack=%b d_ack=%b required=none", i_ack_o, d_ack_o);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_data = i_ack_o ? i_data_o : d_data_o;
        if ({i_ack_o, d_ack_o} !== mon_e[W-1:W-2] ||
            (mon_e[LW] && mon_data !== mon_e[LW-1:0])) begin
          errors++;
          $display("FAIL ack_route i_ack=%b d_ack=%b data=%0h required_acks=%b data=%0h",
                   i_ack_o, d_ack_o, mon_data, mon_e[W-1:W-2], mon_e[LW-1:0]);
        end
      end
    end
  end

  // driver: DUT is in IDLE with requests already set; memory acks on the lat-th busy cycle
  task automatic run_txn(input logic [1:0] g, input logic [AW-1:0] a, input logic w,
                         input logic [LW-1:0] wd, input int lat, input logic [LW-1:0] rd);
    tick();
    check("grant", {254'd0, grant_o}, {254'd0, g});
    for (int c = 0; c < lat; c++) begin
      check("busy_enable", {255'd0, mem_enable_o}, {255'd0, 1'b1});
      check("busy_addr", {224'd0, mem_addr_o}, {224'd0, a});
      check("busy_write", {255'd0, mem_write_o}, {255'd0, w});
      check("busy_wdata", mem_data_o, wd);
      if (c == 0 && g == GNT_D && w) begin
        d_data_i   = ~d_data_i;
        d_addr_i   = 32'hDEAD_0000;
        d_enable_i = 1'b0;
      end
      if (c < lat - 1) tick();
    end
    mem_ack_i  = 1'b1;
    mem_data_i = rd;
    exp_q.push_back({(g == GNT_I), (g == GNT_D), ~w, rd});
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    check("release_enable", {255'd0, mem_enable_o}, 256'd0);
    check("release_grant", {254'd0, grant_o}, 256'd0);
    tick();
    check("idle_enable", {255'd0, mem_enable_o}, 256'd0);
  endtask

  logic [LW-1:0] line_a5, line_5a, line_c3, line_wb, line_rr;
  logic [1:0]    rr_exp[4];

  initial begin
    line_a5 = {32{8'hA5}};
    line_5a = {32{8'h5A}};
    line_c3 = {32{8'hC3}};
    line_wb = {8{32'h1234_5678}};
    line_rr = {16{16'hBEEF}};
`ifdef MEM_ARB_RR_EN
    rr_exp = '{GNT_D, GNT_I, GNT_D, GNT_I};
`else
    rr_exp = '{GNT_D, GNT_D, GNT_D, GNT_D};
`endif

    do_reset();
    check("rst_enable", {255'd0, mem_enable_o}, 256'd0);
    check("rst_grant", {254'd0, grant_o}, 256'd0);
    check("rst_proto_err", {255'd0, proto_err_o}, 256'd0);
    check("rst_write", {255'd0, mem_write_o}, 256'd0);
    check("rst_addr", {224'd0, mem_addr_o}, 256'd0);
    check("rst_data", mem_data_o, 256'd0);

    // icache alone, ack on the 10th busy cycle
    i_enable_i = 1'b1;
    i_addr_i   = 32'h0000_0400;
    run_txn(GNT_I, 32'h0000_0400, 1'b0, 256'd0, 10, line_a5);
    i_enable_i = 1'b0;

    // dcache write-back; inputs change and enable drops mid-transaction
    d_enable_i = 1'b1;
    d_write_i  = 1'b1;
    d_addr_i   = 32'h0000_0200;
    d_data_i   = line_wb;
    run_txn(GNT_D, 32'h0000_0200, 1'b1, line_wb, 4, line_c3);
    d_write_i  = 1'b0;
    d_data_i   = '0;
    check("wb_enable_dropped", {255'd0, mem_enable_o}, 256'd0);

    // simultaneous requests from reset: dcache first, then waiting icache
    do_reset();
    i_enable_i = 1'b1;
    i_addr_i   = 32'h0000_0400;
    d_enable_i = 1'b1;
    d_addr_i   = 32'h0000_0300;
    run_txn(GNT_D, 32'h0000_0300, 1'b0, 256'd0, 3, line_5a);
    d_enable_i = 1'b0;
    run_txn(GNT_I, 32'h0000_0400, 1'b0, 256'd0, 2, line_c3);
    i_enable_i = 1'b0;

    // four back-to-back collisions with both requests held
    do_reset();
    i_enable_i = 1'b1;
    d_enable_i = 1'b1;
    for (int r = 0; r < 4; r++) begin
      run_txn(rr_exp[r], (rr_exp[r] == GNT_I) ? 32'h0000_0400 : 32'h0000_0300,
              1'b0, 256'd0, 2 + r, line_rr ^ LW'(r));
    end
    i_enable_i = 1'b0;
    d_enable_i = 1'b0;

    // stray ack in IDLE
    tick();
    check("pre_stray_proto", {255'd0, proto_err_o}, 256'd0);
    mem_ack_i = 1'b1;
    check("stray_no_iack", {255'd0, i_ack_o}, 256'd0);
    check("stray_no_dack", {255'd0, d_ack_o}, 256'd0);
    tick();
    mem_ack_i = 1'b0;
    check("stray_proto_set", {255'd0, proto_err_o}, {255'd0, 1'b1});
    repeat (3) tick();
    check("stray_proto_sticky", {255'd0, proto_err_o}, {255'd0, 1'b1});

    // reset on the 5th BUSY_D cycle abandons the transaction
    do_reset();
    check("proto_cleared", {255'd0, proto_err_o}, 256'd0);
    d_enable_i = 1'b1;
    d_addr_i   = 32'h0000_0600;
    tick();
    check("abort_grant", {254'd0, grant_o}, {254'd0, GNT_D});
    repeat (4) tick();
    check("abort_busy5", {255'd0, mem_enable_o}, {255'd0, 1'b1});
    rst_i = 1'b1;
    tick();
    rst_i      = 1'b0;
    d_enable_i = 1'b0;
    check("abort_enable", {255'd0, mem_enable_o}, 256'd0);
    check("abort_grant_none", {254'd0, grant_o}, 256'd0);
    repeat (2) tick();
    mem_ack_i  = 1'b1;
    mem_data_i = line_a5;
    check("abort_no_dack", {255'd0, d_ack_o}, 256'd0);
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    repeat (2) tick();

    check("queue_drained", 256'(exp_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
